// File: rtl/elevator_car.sv
// Single elevator car: one request at a time,
// steps one floor per travel interval, then opens the door.
module elevator_car #(
  parameter int FLOORS      = 12,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_floor,
  output logic       req_ready,
  output logic       req_err,
  output logic [3:0] current_floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       arrived
);

  localparam int MW =
    (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW =
    (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MOVE_LAST =
    MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST =
    DW'(DOOR_CYCLES - 1);
  localparam logic [4:0] FLOOR_LIM = 5'(FLOORS);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  state_t          r_state;
  logic [3:0]      r_floor;
  logic [3:0]      r_target;
  logic [MW-1:0]   r_move_cnt;
  logic [DW-1:0]   r_door_cnt;
  logic            r_err;
  logic            r_arrived;

  logic            w_accept;
  logic            w_in_range;
  logic            w_up;
  logic            w_down;
  logic [3:0]      w_next;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_in_range = {1'b0, req_floor} < FLOOR_LIM;
  assign w_up       = r_target > r_floor;
  assign w_down     = r_target < r_floor;
  assign w_next     = w_up ? (r_floor + 4'd1)
                           : (r_floor - 4'd1);

  assign req_ready     = (r_state == IDLE);
  assign door_open     = (r_state == DOOR);
  assign moving_up     = (r_state == MOVE) && w_up;
  assign moving_down   = (r_state == MOVE) && w_down;
  assign current_floor = r_floor;
  assign req_err       = r_err;
  assign arrived       = r_arrived;

  // Car state machine: accept, travel, door dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_floor    <= 4'd0;
      r_target   <= 4'd0;
      r_move_cnt <= '0;
      r_door_cnt <= '0;
      r_err      <= 1'b0;
      r_arrived  <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_arrived <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_in_range) begin
              r_err <= 1'b1;
            end else if (req_floor == r_floor) begin
              r_state    <= DOOR;
              r_arrived  <= 1'b1;
              r_door_cnt <= '0;
            end else begin
              r_target   <= req_floor;
              r_state    <= MOVE;
              r_move_cnt <= '0;
            end
          end
        end
        MOVE: begin
          if (r_move_cnt == MOVE_LAST) begin
            r_move_cnt <= '0;
            r_floor    <= w_next;
            if (w_next == r_target) begin
              r_state    <= DOOR;
              r_arrived  <= 1'b1;
              r_door_cnt <= '0;
            end
          end else begin
            r_move_cnt <= r_move_cnt + 1'b1;
          end
        end
        DOOR: begin
          if (r_door_cnt == DOOR_LAST) begin
            r_state <= IDLE;
          end else begin
            r_door_cnt <= r_door_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/elevator_car.md
# elevator_car

Sequential model of a single elevator car that produces the 4-bit floor number consumed by the combinational elevator controller. It accepts one target-floor request at a time over a valid/ready handshake, steps the car one floor per fixed travel interval, then holds the door open for a fixed interval before accepting the next request. Its `current_floor` output drives the controller's `input_floor` input directly in the system bench.

## Interface
- `FLOORS`, default 12: number of valid floors, numbered 0..FLOORS-1. Legal range 2..16.
- `MOVE_CYCLES`, default 4: clock cycles per one-floor step. Must be ≥1.
- `DOOR_CYCLES`, default 3: clock cycles the door stays open. Must be ≥1.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: a request is present on `req_floor`.
- `req_floor`, input, 4: target floor.
- `req_ready`, output, 1: the car can accept a request. Equals (state==IDLE); combinational from state.
- `req_err`, output, 1: one-cycle pulse when an accepted request has `req_floor` ≥ FLOORS.
- `current_floor`, output, 4: floor the car is at; registered.
- `moving_up`, output, 1: high while in MOVE with target > current_floor.
- `moving_down`, output, 1: high while in MOVE with target < current_floor.
- `door_open`, output, 1: high while in DOOR.
- `arrived`, output, 1: one-cycle pulse on entry to DOOR.

## Operation
- States: IDLE, MOVE, DOOR. Internal registers: `target` (4 bits), `move_cnt`, `door_cnt`.
- Reset (asynchronous, while `rst_n`=0): state=IDLE, current_floor=0, target=0, counters=0, req_err=0, arrived=0. As a result, req_ready=1, door_open=0, moving_up=0 and moving_down=0.
- Handshake: a request is accepted on a rising edge with req_valid=1 and req_ready=1. `req_valid` is ignored while req_ready=0. Requests are neither queued nor buffered.
- IDLE, on acceptance:
  - If req_floor ≥ FLOORS: stay in IDLE and pulse req_err for 1 cycle. Target is unchanged.
  - If req_floor == current_floor: go to DOOR, pulse arrived, set door_cnt=0.
  - Otherwise: set target=req_floor, go to MOVE, set move_cnt=0.
- MOVE:
  - move_cnt increments each cycle.
  - When move_cnt==MOVE_CYCLES-1, current_floor steps by ±1 toward target and move_cnt is reset to 0.
  - If the stepped floor equals target, go to DOOR on the same edge, pulse arrived and set door_cnt=0.
  - current_floor never leaves 0..FLOORS-1 and never wraps.
- DOOR:
  - door_cnt increments each cycle.
  - When door_cnt==DOOR_CYCLES-1, go to IDLE.
- Arithmetic: the ±1 step is 4-bit unsigned. Overflow cannot occur because target < FLOORS ≤ 16.
- Reset mid-operation: the car returns immediately to floor 0 and IDLE. The in-flight request is discarded.
- Simultaneous events: req_err and arrived are never high in the same cycle. In MOVE, the floor step and the state change to DOOR occur on the same edge.

## Timing
- Acceptance edge = E0.
- Travel distance d ≥ 1:
  - current_floor changes after edges E0+k·MOVE_CYCLES, for k=1..d.
  - arrived and door_open rise after edge E0+d·MOVE_CYCLES.
  - door_open stays high for exactly DOOR_CYCLES cycles.
  - req_ready returns to 1 after edge E0+d·MOVE_CYCLES+DOOR_CYCLES.
- Same-floor request: door_open rises after E0 and req_ready returns after E0+DOOR_CYCLES.
- Invalid request: req_err is high during the cycle after E0. req_ready stays 1 throughout, so a new request can be accepted on the next edge.
- moving_up and moving_down are valid the cycle after E0 and drop on the arrival edge.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> immediately current_floor=0, req_ready=1, and door_open, arrived, req_err, moving_up and moving_down all 0.
- Upward trip, defaults (MOVE_CYCLES=4, DOOR_CYCLES=3), request 3 from floor 0:
  - current_floor = 1 after cycle 4, 2 after cycle 8, 3 after cycle 12; moving_up=1 throughout.
  - arrived pulses 1 cycle, door_open=1 for 3 cycles, req_ready=1 at cycle 15.
- Downward trip, request 0 from floor 3:
  - moving_down=1; floors 2, 1, 0 at 4-cycle intervals.
  - arrived pulses at cycle 12; no underflow below 0.
- Same-floor and invalid requests:
  - Request 0 at floor 0 -> door_open next cycle for 3 cycles; current_floor and both moving flags unchanged.
  - Request 12 -> req_err pulse, state stays IDLE, current_floor unchanged.
  - Request 15 on the following cycle -> a second req_err pulse.
- Busy and reset mid-move:
  - Hold req_valid=1 with req_floor=5 during a trip to 3 -> the request is ignored and the car stops at 3.
  - After the door closes, the still-asserted request is accepted.
  - Assert rst_n=0 while at floor 2 and moving toward 7 -> current_floor=0, state IDLE; after reset, a request for 1 completes normally.
- Full range: request 11 from 0 -> 11 steps, arrival at cycle 44, no wrap.
  - With the controller attached, every floor value 0..11 appears once on current_floor in sequence.
